// File: rtl/xout_window_acc_pkg.sv
// Shared types and constants for the XOUT window accumulator.
package xout_window_acc_pkg;

  localparam int DATA_W = 8;
  localparam int SUM_W  = 16;
  localparam int CNT_W  = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Smaller of two samples.
  function automatic logic [DATA_W-1:0] min_sample(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Larger of two samples.
  function automatic logic [DATA_W-1:0] max_sample(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/xout_window_acc.sv
// Window accumulator: collects WINDOW unsigned samples, then presents their
// sum, minimum and maximum until the downstream side takes the result.
//
// Handshake: a transfer happens on a rising CLK edge exactly when VALID and
// READY are both high on that edge. A producer holds VALID and its data
// steady until the transfer. READY carries no dependence on VALID. On the
// input side, IN_READY is high only while collecting (ACCUM) and RST is low.
// On the output side, OUT_VALID is high only while presenting (HOLD).
module xout_window_acc
  import xout_window_acc_pkg::*;
#(
  parameter int WINDOW = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic [SUM_W-1:0]  SUM,
  output logic [DATA_W-1:0] MIN_OUT,
  output logic [DATA_W-1:0] MAX_OUT,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output state_t            STATE_DBG
);

  // The counter value seen when the final sample of a window arrives.
  // With WINDOW=256 this is 255, which still fits the 8-bit counter.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

  state_t              state_q;
  state_t              state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [SUM_W-1:0]    acc_sum_q;
  logic [DATA_W-1:0]   acc_min_q;
  logic [DATA_W-1:0]   acc_max_q;
  logic [SUM_W-1:0]    sum_q;
  logic [DATA_W-1:0]   min_q;
  logic [DATA_W-1:0]   max_q;

  logic                accept;
  logic                first_sample;
  logic                last_sample;
  logic                transfer;
  logic [SUM_W-1:0]    next_sum;
  logic [DATA_W-1:0]   next_min;
  logic [DATA_W-1:0]   next_max;

  // Handshake qualifiers are decoded from registered state only.
  always_comb begin
    IN_READY     = 1'b0;
    OUT_VALID    = 1'b0;
    accept       = 1'b0;
    transfer     = 1'b0;
    first_sample = 1'b0;
    last_sample  = 1'b0;
    IN_READY     = (state_q == ACCUM) && !RST;
    OUT_VALID    = (state_q == HOLD);
    accept       = IN_VALID && IN_READY;
    transfer     = OUT_VALID && OUT_READY;
    first_sample = (cnt_q == '0);
    last_sample  = (cnt_q == LAST_IDX);
  end

  // Running values including the sample currently being accepted; the first
  // sample of a window seeds min/max instead of comparing against stale data.
  always_comb begin
    next_sum = '0;
    next_min = '0;
    next_max = '0;
    next_sum = SUM_W'(acc_sum_q) + SUM_W'(IN_DATA);
    if (first_sample) begin
      next_min = IN_DATA;
      next_max = IN_DATA;
    end else begin
      next_min = min_sample(acc_min_q, IN_DATA);
      next_max = max_sample(acc_max_q, IN_DATA);
    end
  end

  // Next-state logic: close the window on its last sample, reopen on transfer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM: begin
        if (accept && last_sample) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (OUT_READY) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Running accumulators: update per accepted sample, clear on transfer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q     <= '0;
      acc_sum_q <= '0;
      acc_min_q <= '0;
      acc_max_q <= '0;
    end else if (transfer) begin
      cnt_q     <= '0;
      acc_sum_q <= '0;
      acc_min_q <= '0;
      acc_max_q <= '0;
    end else if (accept) begin
      cnt_q     <= cnt_q + CNT_W'(1);
      acc_sum_q <= next_sum;
      acc_min_q <= next_min;
      acc_max_q <= next_max;
    end
  end

  // Result registers: loaded with the completed window and otherwise kept,
  // so the last result survives a transfer until the next window closes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sum_q <= '0;
      min_q <= '0;
      max_q <= '0;
    end else if (accept && last_sample) begin
      sum_q <= next_sum;
      min_q <= next_min;
      max_q <= next_max;
    end
  end

  assign SUM       = sum_q;
  assign MIN_OUT   = min_q;
  assign MAX_OUT   = max_q;
  assign STATE_DBG = state_q;

endmodule

// File: tb/tb_xout_window_acc.sv
// Directed bench for xout_window_acc: three instances (WINDOW 4, 256, 1)
// share clock and reset; inputs change and outputs are sampled on negedge.
module tb_xout_window_acc;
  import xout_window_acc_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- instance A: WINDOW=4 ----------------
  logic [7:0]  a_in_data = '0;
  logic        a_in_valid = 1'b0;
  logic        a_in_ready;
  logic [15:0] a_sum;
  logic [7:0]  a_min, a_max;
  logic        a_out_valid;
  logic        a_out_ready = 1'b0;
  state_t      a_state;

  xout_window_acc #(.WINDOW(4)) dut_a (
    .CLK(clk), .RST(rst), .IN_DATA(a_in_data), .IN_VALID(a_in_valid),
    .IN_READY(a_in_ready), .SUM(a_sum), .MIN_OUT(a_min), .MAX_OUT(a_max),
    .OUT_VALID(a_out_valid), .OUT_READY(a_out_ready), .STATE_DBG(a_state)
  );

  // ---------------- instance B: WINDOW=256 ----------------
  logic [7:0]  b_in_data = '0;
  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [15:0] b_sum;
  logic [7:0]  b_min, b_max;
  logic        b_out_valid;
  logic        b_out_ready = 1'b0;
  state_t      b_state;

  xout_window_acc #(.WINDOW(256)) dut_b (
    .CLK(clk), .RST(rst), .IN_DATA(b_in_data), .IN_VALID(b_in_valid),
    .IN_READY(b_in_ready), .SUM(b_sum), .MIN_OUT(b_min), .MAX_OUT(b_max),
    .OUT_VALID(b_out_valid), .OUT_READY(b_out_ready), .STATE_DBG(b_state)
  );

  // ---------------- instance C: WINDOW=1 ----------------
  logic [7:0]  c_in_data = '0;
  logic        c_in_valid = 1'b0;
  logic        c_in_ready;
  logic [15:0] c_sum;
  logic [7:0]  c_min, c_max;
  logic        c_out_valid;
  logic        c_out_ready = 1'b0;
  state_t      c_state;

  xout_window_acc #(.WINDOW(1)) dut_c (
    .CLK(clk), .RST(rst), .IN_DATA(c_in_data), .IN_VALID(c_in_valid),
    .IN_READY(c_in_ready), .SUM(c_sum), .MIN_OUT(c_min), .MAX_OUT(c_max),
    .OUT_VALID(c_out_valid), .OUT_READY(c_out_ready), .STATE_DBG(c_state)
  );

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks (entered and left on a negedge) ----------------
  task automatic send_a(input logic [7:0] d);
    int t = 0;
    while (!a_in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("a_send_timeout", 32'(t < 50), 32'd1);
    a_in_valid = 1'b1;
    a_in_data  = d;
    @(negedge clk);
    a_in_valid = 1'b0;
    a_in_data  = 8'($urandom_range(0, 255));
  endtask

  task automatic idle_a(input int n);
    for (int i = 0; i < n; i++) begin
      a_in_data = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
  endtask

  task automatic release_a();
    chk("a_handshake_in_ready", 32'(a_in_ready), 32'd0);
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
    a_in_valid  = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d);
    int t = 0;
    while (!b_in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("b_send_timeout", 32'(t < 50), 32'd1);
    b_in_valid = 1'b1;
    b_in_data  = d;
    @(negedge clk);
    b_in_valid = 1'b0;
  endtask

  task automatic send_c(input logic [7:0] d);
    int t = 0;
    while (!c_in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("c_send_timeout", 32'(t < 50), 32'd1);
    c_in_valid = 1'b1;
    c_in_data  = d;
    @(negedge clk);
    c_in_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready_low", 32'(a_in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Reset state.
    chk("rst_sum", 32'(a_sum), 32'd0);
    chk("rst_min", 32'(a_min), 32'd0);
    chk("rst_max", 32'(a_max), 32'd0);
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);
    chk("rst_state", 32'(a_state), 32'(ACCUM));

    // Window 1: four equal samples back to back.
    send_a(8'd13);
    send_a(8'd13);
    send_a(8'd13);
    chk("w1_not_yet_valid", 32'(a_out_valid), 32'd0);
    send_a(8'd13);
    chk("w1_out_valid", 32'(a_out_valid), 32'd1);
    chk("w1_state", 32'(a_state), 32'(HOLD));
    chk("w1_sum", 32'(a_sum), 32'd52);
    chk("w1_min", 32'(a_min), 32'd13);
    chk("w1_max", 32'(a_max), 32'd13);
    release_a();
    chk("w1_after_xfer_valid", 32'(a_out_valid), 32'd0);
    chk("w1_after_xfer_ready", 32'(a_in_ready), 32'd1);
    chk("w1_kept_sum", 32'(a_sum), 32'd52);

    // Window 2: extremes with IN_VALID gaps and junk on IN_DATA.
    send_a(8'd0);
    idle_a(2);
    send_a(8'd255);
    idle_a(1);
    send_a(8'd7);
    idle_a(3);
    chk("w2_not_yet_valid", 32'(a_out_valid), 32'd0);
    chk("w2_old_sum_kept", 32'(a_sum), 32'd52);
    send_a(8'd100);
    chk("w2_out_valid", 32'(a_out_valid), 32'd1);
    chk("w2_sum", 32'(a_sum), 32'd362);
    chk("w2_min", 32'(a_min), 32'd0);
    chk("w2_max", 32'(a_max), 32'd255);

    // Hold for 5 cycles with OUT_READY low while samples are offered.
    for (int i = 0; i < 5; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 8'd99;
      @(negedge clk);
      chk("hold_valid", 32'(a_out_valid), 32'd1);
      chk("hold_in_ready", 32'(a_in_ready), 32'd0);
      chk("hold_sum", 32'(a_sum), 32'd362);
      chk("hold_min", 32'(a_min), 32'd0);
      chk("hold_max", 32'(a_max), 32'd255);
    end
    release_a();
    chk("w2_kept_sum", 32'(a_sum), 32'd362);

    // Window 3: offered samples during hold must not have been counted.
    send_a(8'd1);
    send_a(8'd2);
    send_a(8'd3);
    chk("w3_not_yet_valid", 32'(a_out_valid), 32'd0);
    send_a(8'd4);
    chk("w3_out_valid", 32'(a_out_valid), 32'd1);
    chk("w3_sum", 32'(a_sum), 32'd10);
    chk("w3_min", 32'(a_min), 32'd1);
    chk("w3_max", 32'(a_max), 32'd4);
    release_a();

    // Mid-window reset after two accepted samples.
    send_a(8'd50);
    send_a(8'd60);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_sum", 32'(a_sum), 32'd0);
    chk("mrst_min", 32'(a_min), 32'd0);
    chk("mrst_max", 32'(a_max), 32'd0);
    chk("mrst_out_valid", 32'(a_out_valid), 32'd0);
    send_a(8'd5);
    send_a(8'd5);
    send_a(8'd5);
    chk("w4_not_yet_valid", 32'(a_out_valid), 32'd0);
    send_a(8'd5);
    chk("w4_out_valid", 32'(a_out_valid), 32'd1);
    chk("w4_sum", 32'(a_sum), 32'd20);
    chk("w4_min", 32'(a_min), 32'd5);
    chk("w4_max", 32'(a_max), 32'd5);

    // Reset while a result is held discards it.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("hrst_out_valid", 32'(a_out_valid), 32'd0);
    chk("hrst_sum", 32'(a_sum), 32'd0);
    chk("hrst_state", 32'(a_state), 32'(ACCUM));

    // WINDOW=256, all samples 255: largest possible sum.
    for (int i = 0; i < 255; i++) send_b(8'd255);
    chk("b_not_yet_valid", 32'(b_out_valid), 32'd0);
    send_b(8'd255);
    chk("b_out_valid", 32'(b_out_valid), 32'd1);
    chk("b_sum", 32'(b_sum), 32'd65280);
    chk("b_min", 32'(b_min), 32'd255);
    chk("b_max", 32'(b_max), 32'd255);

    // WINDOW=1: every sample is its own window.
    send_c(8'd9);
    chk("c1_out_valid", 32'(c_out_valid), 32'd1);
    chk("c1_sum", 32'(c_sum), 32'd9);
    chk("c1_min", 32'(c_min), 32'd9);
    chk("c1_max", 32'(c_max), 32'd9);
    chk("c1_handshake_in_ready", 32'(c_in_ready), 32'd0);
    c_out_ready = 1'b1;
    @(negedge clk);
    c_out_ready = 1'b0;
    chk("c1_after_xfer_valid", 32'(c_out_valid), 32'd0);
    send_c(8'd200);
    chk("c2_out_valid", 32'(c_out_valid), 32'd1);
    chk("c2_sum", 32'(c_sum), 32'd200);
    chk("c2_min", 32'(c_min), 32'd200);
    chk("c2_max", 32'(c_max), 32'd200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
